// File: rtl/cam_capture_stream.sv
// cam_capture_stream
//   Camera byte stream capture for the PixelClk domain. Camera bytes are
//   assembled into pixels of BYTES_PER_PIXEL bytes and written to the
//   camera-input FIFO as {marker, pixel} words. Each frame begins with a
//   start marker {1, 0}. An end marker {1, all-ones} is optional. The block
//   also applies a crop window and power-of-2 decimation, drops the rest of
//   a frame when the FIFO overflows, and checks the length of every line.
//
// Ports
//   clk            pixel clock
//   reset_p        synchronous active-high reset
//   enable         capture enable (memory calibration done)
//   cam_vsync      camera VSYNC, high during vertical blanking
//   href           line-valid; each high cycle carries one camera byte
//   p_data         camera byte
//   decim          decimation shift: keep col/row whose low decim bits are 0
//   fifo_full      downstream FIFO full
//   fifo_data      {marker, pixel} word
//   fifo_wr_en     one-cycle write strobe
//   capturing      high while a frame is being captured
//   frame_count    completed frames (wraps)
//   dropped_frames frames dropped because of overflow (saturates at 255)
//   overflow       sticky: a word was needed while fifo_full was high
//   line_len_err   sticky: wrong line byte count, or line beyond FRAME_HEIGHT
//
// fifo_full is sampled in the same cycle as the event that needs the write
// (frame start, last byte of a kept pixel, frame end). The word itself is
// presented one cycle later.
module cam_capture_stream #(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int FIRST_BYTE_MSB  = 1,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int CROP_X0         = 0,
  parameter int CROP_Y0         = 0,
  parameter int CROP_W          = 640,
  parameter int CROP_H          = 480,
  parameter int EOF_MARKER_EN   = 0,
  localparam int PIX_W          = DATA_WIDTH * BYTES_PER_PIXEL
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  enable,
  input  logic                  cam_vsync,
  input  logic                  href,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic [1:0]            decim,
  input  logic                  fifo_full,
  output logic [PIX_W:0]        fifo_data,
  output logic                  fifo_wr_en,
  output logic                  capturing,
  output logic [15:0]           frame_count,
  output logic [7:0]            dropped_frames,
  output logic                  overflow,
  output logic                  line_len_err
);

  localparam int BI_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int CNT_W = 16;

  localparam logic [31:0] LINE_BYTES = 32'(FRAME_WIDTH * BYTES_PER_PIXEL);
  localparam logic [31:0] FH_LIM     = 32'(FRAME_HEIGHT);
  localparam logic [31:0] X_LO       = 32'(CROP_X0);
  localparam logic [31:0] X_HI       = 32'(CROP_X0 + CROP_W);
  localparam logic [31:0] Y_LO       = 32'(CROP_Y0);
  localparam logic [31:0] Y_HI       = 32'(CROP_Y0 + CROP_H);

  localparam logic [PIX_W:0] SOF_WORD = {1'b1, {PIX_W{1'b0}}};
  localparam logic [PIX_W:0] EOF_WORD = '1;

  typedef enum logic [2:0] {
    WAIT_ENABLE,
    WAIT_BLANK,
    WAIT_FRAME_START,
    ROW_CAPTURE,
    FRAME_DROP
  } state_t;

  state_t state, state_next;

  logic [BI_W-1:0]  byte_idx;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] line_bytes;
  logic             href_d;
  logic [PIX_W-1:0] pix_acc;
  logic [PIX_W-1:0] pix_full;

  logic start_ok, start_drop;
  logic byte_en, pix_done, pix_wr, pix_ovf;
  logic line_end, frame_end, eof_wr, eof_ovf;
  logic keep;

  logic [31:0] col32, row32, dmask;

  // Bit position of byte k inside the pixel word.
  function automatic int unsigned slot_lsb(input int unsigned k);
    if (FIRST_BYTE_MSB != 0) return PIX_W - (k + 1) * DATA_WIDTH;
    else                     return k * DATA_WIDTH;
  endfunction

  // Current pixel with the byte on p_data merged into its slot.
  always_comb begin
    pix_full = pix_acc;
    for (int unsigned k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (32'(byte_idx) == k) pix_full[slot_lsb(k) +: DATA_WIDTH] = p_data;
    end
  end

  // Crop window, decimation grid, and the frame-height limit.
  always_comb begin
    col32 = 32'(col);
    row32 = 32'(row);
    dmask = (32'd1 << decim) - 32'd1;
    keep  = (col32 >= X_LO) && (col32 < X_HI) &&
            (row32 >= Y_LO) && (row32 < Y_HI) &&
            ((col32 & dmask) == '0) && ((row32 & dmask) == '0) &&
            (row32 < FH_LIM);
  end

  // Next-state and event decode. Deasserting enable overrides everything.
  // A vsync rise in ROW_CAPTURE takes priority over any byte or line end
  // in the same cycle.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_drop = 1'b0;
    byte_en    = 1'b0;
    pix_done   = 1'b0;
    pix_wr     = 1'b0;
    pix_ovf    = 1'b0;
    line_end   = 1'b0;
    frame_end  = 1'b0;
    eof_wr     = 1'b0;
    eof_ovf    = 1'b0;
    if (!enable) begin
      state_next = WAIT_ENABLE;
    end else begin
      case (state)
        WAIT_ENABLE: state_next = WAIT_BLANK;
        WAIT_BLANK: begin
          if (cam_vsync) state_next = WAIT_FRAME_START;
        end
        WAIT_FRAME_START: begin
          if (!cam_vsync) begin
            if (fifo_full) begin
              start_drop = 1'b1;
              state_next = FRAME_DROP;
            end else begin
              start_ok   = 1'b1;
              state_next = ROW_CAPTURE;
            end
          end
        end
        ROW_CAPTURE: begin
          if (cam_vsync) begin
            frame_end  = 1'b1;
            state_next = WAIT_FRAME_START;
            if (EOF_MARKER_EN != 0) begin
              if (fifo_full) eof_ovf = 1'b1;
              else           eof_wr  = 1'b1;
            end
          end else if (href) begin
            byte_en = 1'b1;
            if (byte_idx == BI_W'(BYTES_PER_PIXEL - 1)) begin
              pix_done = 1'b1;
              if (keep) begin
                if (fifo_full) begin
                  pix_ovf    = 1'b1;
                  state_next = FRAME_DROP;
                end else begin
                  pix_wr = 1'b1;
                end
              end
            end
          end else if (href_d) begin
            line_end = 1'b1;
          end
        end
        FRAME_DROP: begin
          if (cam_vsync) state_next = WAIT_FRAME_START;
        end
        default: state_next = WAIT_ENABLE;
      endcase
    end
  end

  assign capturing = (state == ROW_CAPTURE);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state          <= WAIT_ENABLE;
      byte_idx       <= '0;
      col            <= '0;
      row            <= '0;
      line_bytes     <= '0;
      href_d         <= 1'b0;
      pix_acc        <= '0;
      fifo_data      <= '0;
      fifo_wr_en     <= 1'b0;
      frame_count    <= '0;
      dropped_frames <= '0;
      overflow       <= 1'b0;
      line_len_err   <= 1'b0;
    end else begin
      state      <= state_next;
      fifo_wr_en <= start_ok | pix_wr | eof_wr;

      if (start_ok)    fifo_data <= SOF_WORD;
      else if (eof_wr) fifo_data <= EOF_WORD;
      else if (pix_wr) fifo_data <= {1'b0, pix_full};

      if (state == ROW_CAPTURE) href_d <= href & ~cam_vsync;

      if (start_ok) begin
        byte_idx   <= '0;
        col        <= '0;
        row        <= '0;
        line_bytes <= '0;
        href_d     <= 1'b0;
      end

      if (byte_en) begin
        pix_acc    <= pix_full;
        line_bytes <= (line_bytes == '1) ? line_bytes : line_bytes + 1'b1;
        if (pix_done) begin
          byte_idx <= '0;
          col      <= (col == '1) ? col : col + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end

      // A short line leaves a partial pixel behind; clearing byte_idx
      // discards it.
      if (line_end) begin
        byte_idx   <= '0;
        col        <= '0;
        line_bytes <= '0;
        row        <= (row == '1) ? row : row + 1'b1;
        if ((32'(line_bytes) != LINE_BYTES) || (row32 >= FH_LIM))
          line_len_err <= 1'b1;
      end

      if (frame_end) frame_count <= frame_count + 16'd1;

      if (start_drop || pix_ovf) begin
        overflow <= 1'b1;
        if (dropped_frames != 8'hFF) dropped_frames <= dropped_frames + 8'd1;
      end
      if (eof_ovf) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture_stream.sv
// Testbench for cam_capture_stream. There are three instances with
// different configurations. They share every input except enable, so only
// the instance under test is active. Randomized frames are checked against
// a frame/line/pixel level reference model and an expected-word queue.
module tb_cam_capture_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic [2:0] en   = '0;
  logic       vs   = 1'b1;
  logic       hr   = 1'b0;
  logic       full = 1'b0;
  logic [7:0] pd   = '0;
  logic [1:0] dc   = '0;

  logic [16:0] fd0, fd1;
  logic [24:0] fd2;
  logic        wr0, wr1, wr2, cap0, cap1, cap2;
  logic [15:0] fc0, fc1, fc2;
  logic [7:0]  df0, df1, df2;
  logic        ov0, ov1, ov2, le0, le1, le2;

  // 4x3, 2 bytes/pixel, first byte in the MSBs, full crop, end marker on
  cam_capture_stream #(.DATA_WIDTH(8), .BYTES_PER_PIXEL(2), .FIRST_BYTE_MSB(1),
    .FRAME_WIDTH(4), .FRAME_HEIGHT(3), .CROP_X0(0), .CROP_Y0(0), .CROP_W(4),
    .CROP_H(3), .EOF_MARKER_EN(1)) u0 (
    .clk(clk), .reset_p(rst), .enable(en[0]), .cam_vsync(vs), .href(hr),
    .p_data(pd), .decim(dc), .fifo_full(full), .fifo_data(fd0),
    .fifo_wr_en(wr0), .capturing(cap0), .frame_count(fc0),
    .dropped_frames(df0), .overflow(ov0), .line_len_err(le0));

  // 4x3, first byte in the LSBs, crop x 1..2, row 1 only
  cam_capture_stream #(.DATA_WIDTH(8), .BYTES_PER_PIXEL(2), .FIRST_BYTE_MSB(0),
    .FRAME_WIDTH(4), .FRAME_HEIGHT(3), .CROP_X0(1), .CROP_Y0(1), .CROP_W(2),
    .CROP_H(1), .EOF_MARKER_EN(0)) u1 (
    .clk(clk), .reset_p(rst), .enable(en[1]), .cam_vsync(vs), .href(hr),
    .p_data(pd), .decim(dc), .fifo_full(full), .fifo_data(fd1),
    .fifo_wr_en(wr1), .capturing(cap1), .frame_count(fc1),
    .dropped_frames(df1), .overflow(ov1), .line_len_err(le1));

  // 4x4, 3 bytes/pixel
  cam_capture_stream #(.DATA_WIDTH(8), .BYTES_PER_PIXEL(3), .FIRST_BYTE_MSB(1),
    .FRAME_WIDTH(4), .FRAME_HEIGHT(4), .CROP_X0(0), .CROP_Y0(0), .CROP_W(4),
    .CROP_H(4), .EOF_MARKER_EN(0)) u2 (
    .clk(clk), .reset_p(rst), .enable(en[2]), .cam_vsync(vs), .href(hr),
    .p_data(pd), .decim(dc), .fifo_full(full), .fifo_data(fd2),
    .fifo_wr_en(wr2), .capturing(cap2), .frame_count(fc2),
    .dropped_frames(df2), .overflow(ov2), .line_len_err(le2));

  function automatic int c_bpp(input int d); return (d == 2) ? 3 : 2; endfunction
  function automatic int c_msb(input int d); return (d == 1) ? 0 : 1; endfunction
  function automatic int c_fw (input int d); return 4; endfunction
  function automatic int c_fh (input int d); return (d == 2) ? 4 : 3; endfunction
  function automatic int c_x0 (input int d); return (d == 1) ? 1 : 0; endfunction
  function automatic int c_w  (input int d); return (d == 1) ? 2 : 4; endfunction
  function automatic int c_y0 (input int d); return (d == 1) ? 1 : 0; endfunction
  function automatic int c_h  (input int d); return (d == 1) ? 1 : c_fh(d); endfunction
  function automatic int c_eof(input int d); return (d == 0) ? 1 : 0; endfunction

  typedef struct packed {
    logic        wr;
    logic [32:0] data;
    logic        cap;
    logic [15:0] fc;
    logic [7:0]  df;
    logic        ovf;
    logic        lle;
  } obs_t;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      0:       o = '{wr0, 33'(fd0), cap0, fc0, df0, ov0, le0};
      1:       o = '{wr1, 33'(fd1), cap1, fc1, df1, ov1, le1};
      default: o = '{wr2, 33'(fd2), cap2, fc2, df2, ov2, le2};
    endcase
    return o;
  endfunction

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model. m_state: 0 = not in a frame, 1 = capturing, 2 = dropping.
  int                cur = 0;
  int                m_state, m_row, m_col, m_k, m_nb, m_frames, m_dropped;
  bit                m_ovf, m_lle;
  longint unsigned   m_pix;
  longint unsigned   expq[$];

  task automatic model_clear();
    m_state = 0; m_row = 0; m_col = 0; m_k = 0; m_nb = 0;
    m_frames = 0; m_dropped = 0; m_ovf = 0; m_lle = 0; m_pix = 0;
    expq.delete();
  endtask

  task automatic model_drop();
    m_state = 2;
    m_ovf   = 1;
    if (m_dropped < 255) m_dropped++;
  endtask

  task automatic model_start(input bit f);
    if (f) model_drop();
    else begin
      expq.push_back(64'd1 << (8 * c_bpp(cur)));
      m_state = 1; m_row = 0; m_col = 0; m_k = 0; m_nb = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit f);
    int bpp, sh, c, msk;
    bit keep;
    if (m_state != 1) return;
    bpp = c_bpp(cur);
    if (m_k == 0) m_pix = 0;
    sh = (c_msb(cur) != 0) ? 8 * (bpp - 1 - m_k) : 8 * m_k;
    m_pix = m_pix | (longint'(b) << sh);
    m_nb++;
    m_k++;
    if (m_k == bpp) begin
      m_k = 0;
      c = m_col;
      m_col++;
      msk = (1 << dc) - 1;
      keep = (c >= c_x0(cur)) && (c < c_x0(cur) + c_w(cur)) &&
             (m_row >= c_y0(cur)) && (m_row < c_y0(cur) + c_h(cur)) &&
             ((c & msk) == 0) && ((m_row & msk) == 0) && (m_row < c_fh(cur));
      if (keep) begin
        if (f) model_drop();
        else   expq.push_back(m_pix);
      end
    end
  endtask

  task automatic model_line_end();
    if (m_state != 1) return;
    if (m_nb != c_fw(cur) * c_bpp(cur) || m_row >= c_fh(cur)) m_lle = 1;
    m_row++; m_col = 0; m_k = 0; m_nb = 0;
  endtask

  task automatic model_frame_end(input bit f);
    if (m_state == 1) begin
      m_frames++;
      if (c_eof(cur) != 0) begin
        if (f) m_ovf = 1;
        else   expq.push_back((64'd1 << (8 * c_bpp(cur) + 1)) - 64'd1);
      end
    end
    m_state = 0;
  endtask

  // Write monitor: every strobe from any instance must match the queue head.
  always @(negedge clk) begin
    obs_t o;
    for (int d = 0; d < 3; d++) begin
      o = get_obs(d);
      if (o.wr === 1'b1) begin
        check_eq("wr_dut", 64'(d), 64'(cur));
        if (expq.size() == 0) check_eq("spurious_wr", 64'(o.wr), 64'd0);
        else                  check_eq("word", 64'(o.data), expq.pop_front());
      end
    end
  end

  function automatic bit hit(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic cyc(input logic v, input logic h, input logic [7:0] b, input logic f);
    @(negedge clk);
    vs = v; hr = h; pd = b; full = f;
  endtask

  task automatic reset_checks();
    obs_t o;
    o = get_obs(cur);
    check_eq("rst_wr_en", 64'(o.wr), 64'd0);
    check_eq("rst_data", 64'(o.data), 64'd0);
    check_eq("rst_capturing", 64'(o.cap), 64'd0);
    check_eq("rst_frame_count", 64'(o.fc), 64'd0);
    check_eq("rst_dropped", 64'(o.df), 64'd0);
    check_eq("rst_overflow", 64'(o.ovf), 64'd0);
    check_eq("rst_line_len_err", 64'(o.lle), 64'd0);
  endtask

  task automatic frame_checks();
    obs_t o;
    o = get_obs(cur);
    check_eq("frame_count", 64'(o.fc), 64'(m_frames));
    check_eq("dropped_frames", 64'(o.df), 64'(m_dropped));
    check_eq("overflow", 64'(o.ovf), 64'(m_ovf));
    check_eq("line_len_err", 64'(o.lle), 64'(m_lle));
    check_eq("capturing_idle", 64'(o.cap), 64'd0);
    check_eq("words_pending", 64'(expq.size()), 64'd0);
  endtask

  // One frame: blank, start, nlines lines (line dl gets dlen extra bytes),
  // then the vsync rise. pct is the fifo_full probability in percent.
  // abort_line >= 0 pulses enable low after that line.
  task automatic frame(input int nlines, input int dl, input int dlen,
                       input int pct, input bit seq, input int abort_line);
    int nom, len, n;
    logic [7:0] b;
    bit f;
    obs_t o;
    nom = c_fw(cur) * c_bpp(cur);
    n = 0;
    repeat (3) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    f = hit(pct);
    cyc(1'b0, 1'b0, 8'($urandom), f);
    model_start(f);
    cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
    o = get_obs(cur);
    check_eq("capturing_in_frame", 64'(o.cap), 64'(m_state == 1));
    for (int l = 0; l < nlines; l++) begin
      len = nom + ((l == dl) ? dlen : 0);
      for (int i = 0; i < len; i++) begin
        b = seq ? 8'((n + 1) * 17) : 8'($urandom);
        n++;
        f = hit(pct);
        cyc(1'b0, 1'b1, b, f);
        model_byte(b, f);
      end
      cyc(1'b0, 1'b0, 8'($urandom), hit(pct));
      model_line_end();
      cyc(1'b0, 1'b0, 8'($urandom), hit(pct));
      if (l == abort_line) begin
        @(negedge clk) en[cur] = 1'b0;
        model_clear_frame();
        @(negedge clk) en[cur] = 1'b1;
      end
    end
    // href may be high here too: the vsync rise must win over the byte.
    f = hit(pct);
    cyc(1'b1, 1'($urandom), 8'($urandom), f);
    model_frame_end(f);
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    frame_checks();
  endtask

  task automatic model_clear_frame();
    m_state = 0;
  endtask

  task automatic reset_mid_line();
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    model_start(1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
      model_byte(pd, 1'b0);
    end
    @(negedge clk) rst = 1'b1;
    check_eq("words_before_reset", 64'(expq.size()), 64'd0);
    model_clear();
    @(negedge clk);
    reset_checks();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic run_dut(input int d);
    int fh;
    cur = d;
    rst = 1'b1;
    en  = '0;
    hr  = 1'b0;
    vs  = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    en[d] = 1'b1;
    fh = c_fh(d);
    dc = 2'd0; frame(fh, -1, 0, 0, 1'b1, -1);
    dc = 2'd1; frame(fh, -1, 0, 0, 1'b0, -1);
    dc = 2'd2; frame(fh, -1, 0, 0, 1'b0, -1);
    dc = 2'd3; frame(fh, -1, 0, 0, 1'b0, -1);
    repeat (5) begin
      dc = 2'($urandom_range(3));
      frame(fh, -1, 0, 30, 1'b0, -1);
    end
    dc = 2'd0; frame(fh, -1, 0, 0, 1'b0, -1);
    if (d == 1) frame(fh, -1, 0, 0, 1'b0, 0);
    frame(fh, 1, -1, 0, 1'b0, -1);
    frame(fh, 2, 2, 0, 1'b0, -1);
    frame(fh + 1, -1, 0, 0, 1'b0, -1);
    if (d == 0) reset_mid_line();
    en = '0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) run_dut(d);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
